// File: rtl/cpu_core_param_if.sv
// -----------------------------------------------------------------------------
// cpu_core_param_if
// Unified memory port of the multicycle core. A transaction completes at a
// rising edge where mem_req and mem_ready are both high.
//
//   mem_req    master->slave  transaction request
//   mem_we     master->slave  1 = write, 0 = read (valid while mem_req)
//   mem_addr   master->slave  word address
//   mem_wdata  master->slave  store data
//   mem_rdata  slave->master  read data, valid in the cycle mem_ready = 1
//   mem_ready  slave->master  completes the pending request
// -----------------------------------------------------------------------------
interface cpu_core_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/cpu_core_param.sv
// -----------------------------------------------------------------------------
// cpu_core_param
// Parametrised multicycle CPU core: 16-bit instruction set (MOV, ALU, LDR,
// STR, conditional branch, HALT) over a DATA_W-bit datapath, with a single
// req/ready memory port shared by instruction fetch and data access.
// DATA_W must be >= 16 and DBG_W <= DATA_W.
//
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   mem     mst  memory port (cpu_core_param_if.master)
//   halted  out  core has executed HALT
//   r0_out  out  R0[DBG_W-1:0] for the board display
// -----------------------------------------------------------------------------
module cpu_core_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 8,
   parameter int DBG_W    = 10,
   parameter int RESET_PC = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   cpu_core_param_if.master          mem,
   output logic                      halted,
   output logic [DBG_W-1:0]          r0_out
);

   localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

   localparam logic [2:0] OPC_NOP  = 3'b000;
   localparam logic [2:0] OPC_BR   = 3'b001;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       ir;
   logic [DATA_W-1:0] regs [8];
   logic [DATA_W-1:0] a, b, c;
   logic              z, n, v;

   // Instruction fields
   logic [2:0] opcode, rn, rd, rm, cond;
   logic [1:0] op, sh;
   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];
   assign cond   = ir[10:8];

   logic [DATA_W-1:0] sximm5, sximm8;
   logic [ADDR_W-1:0] br_off;
   assign sximm5 = DATA_W'($signed(ir[4:0]));
   assign sximm8 = DATA_W'($signed(ir[7:0]));
   // Branch offset is sign-extended (or truncated) to the PC width so the
   // target wraps modulo 2^ADDR_W.
   assign br_off = ADDR_W'($signed(ir[7:0]));

   // MOV immediate names its destination in the Rn field (imm8 overlays Rd).
   logic [2:0] wb_idx;
   assign wb_idx = (opcode == OPC_MOV && op == 2'b10) ? rn : rd;

   logic [DATA_W-1:0] alu_sum, alu_diff, ea_sum;
   logic              alu_v;
   assign alu_sum  = a + b;
   assign alu_diff = a - b;
   assign ea_sum   = a + sximm5;
   // Signed overflow of A-B: operands differ in sign and result sign differs from A.
   assign alu_v    = (a[DATA_W-1] ^ b[DATA_W-1]) & (alu_diff[DATA_W-1] ^ a[DATA_W-1]);

   function automatic logic [DATA_W-1:0] shift_b(input logic [DATA_W-1:0] x,
                                                 input logic [1:0]        s);
      case (s)
         2'b01:   return {x[DATA_W-2:0], 1'b0};
         2'b10:   return {1'b0, x[DATA_W-1:1]};
         2'b11:   return {x[DATA_W-1], x[DATA_W-1:1]};
         default: return x;
      endcase
   endfunction

   function automatic logic cond_ok(input logic [2:0] cc, input logic zf,
                                    input logic nf, input logic vf);
      case (cc)
         3'b000:  return 1'b1;
         3'b001:  return zf;
         3'b010:  return ~zf;
         3'b011:  return nf ^ vf;
         3'b100:  return (nf ^ vf) | zf;
         default: return 1'b0;
      endcase
   endfunction

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   logic              req_o, we_o;
   logic [ADDR_W-1:0] addr_o;
   logic [DATA_W-1:0] wdata_o;

   // Outputs depend on state only, so an asynchronous reset drops mem_req
   // immediately and abandons any stalled transaction.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned and no latch is inferred.
      state_nxt = state;
      req_o     = 1'b0;
      we_o      = 1'b0;
      addr_o    = '0;
      wdata_o   = '0;
      case (state)
         S_IDLE:   state_nxt = S_FETCH;
         S_FETCH: begin
            req_o  = 1'b1;
            addr_o = pc;
            if (mem.mem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: state_nxt = (opcode == OPC_NOP) ? S_FETCH : S_EXEC;
         S_EXEC: begin
            case (opcode)
               OPC_BR:           state_nxt = S_FETCH;
               OPC_ALU:          state_nxt = (op == 2'b01) ? S_FETCH : S_WB;
               OPC_LDR, OPC_STR: state_nxt = S_MEM;
               OPC_HALT:         state_nxt = S_HALT;
               default:          state_nxt = S_WB;
            endcase
         end
         S_MEM: begin
            req_o  = 1'b1;
            addr_o = addr;
            if (opcode == OPC_STR) begin
               we_o    = 1'b1;
               wdata_o = regs[rd];
            end
            if (mem.mem_ready) state_nxt = (opcode == OPC_STR) ? S_FETCH : S_WB;
         end
         S_WB:     state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign mem.mem_req   = req_o;
   assign mem.mem_we    = we_o;
   assign mem.mem_addr  = addr_o;
   assign mem.mem_wdata = wdata_o;
   assign halted        = (state == S_HALT);
   assign r0_out        = regs[0][DBG_W-1:0];

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc   <= RESET_PC_V;
         ir   <= '0;
         addr <= '0;
         a    <= '0;
         b    <= '0;
         c    <= '0;
         z    <= 1'b0;
         n    <= 1'b0;
         v    <= 1'b0;
         // NOTE: the register bank is eight flops, not a RAM, so clearing it
         // on reset is legal and makes R0..R7 start from zero.
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem.mem_ready) begin
                  ir <= mem.mem_rdata[15:0];
                  pc <= pc + PC_ONE;
               end
            end
            S_DECODE: begin
               a <= regs[rn];
               b <= shift_b(regs[rm], sh);
            end
            S_EXEC: begin
               case (opcode)
                  OPC_MOV: c <= (op == 2'b10) ? sximm8 : b;
                  OPC_ALU: begin
                     case (op)
                        2'b00: c <= alu_sum;
                        2'b01: begin
                           z <= (alu_diff == '0);
                           n <= alu_diff[DATA_W-1];
                           v <= alu_v;
                        end
                        2'b10: c <= a & b;
                        default: c <= ~b;
                     endcase
                  end
                  OPC_BR: begin
                     // pc already points past the branch
                     if (cond_ok(cond, z, n, v)) pc <= pc + br_off;
                  end
                  OPC_LDR, OPC_STR: addr <= ea_sum[ADDR_W-1:0];
                  default: ;
               endcase
            end
            S_MEM: begin
               if (mem.mem_ready && opcode == OPC_LDR) c <= mem.mem_rdata;
            end
            S_WB: regs[wb_idx] <= c;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
- Parametrised multicycle successor to the lab CPU top: same 16-bit instruction set (MOV, ALU, LDR, STR, conditional branch), plus HALT.
- Generalised datapath width, address width and debug width.
- Unified memory port with a req/ready handshake, so instruction and data memories may stall the core.
- Sits between the DE1 top level and the memory/IO wrapper; drives R0 to the board display.

Parameters:
- DATA_W, 16: register/ALU/memory data width; must be >= 16.
- ADDR_W, 8: memory word address width; PC width.
- DBG_W, 10: width of R0 debug output; must be <= DATA_W.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  transaction completes at a rising edge where mem_req=1 and mem_ready=1
- halted  out  1  core has executed HALT
- r0_out  out  DBG_W  R0[DBG_W-1:0]

Behaviour:
- Instruction fields:
  - opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], cond[10:8].
  - imm5[4:0] sign-extended to DATA_W; imm8[7:0] sign-extended to DATA_W (MOV) or to ADDR_W (branch).
- Shifter on B operand:
  - sh 00 = none, 01 = LSL1, 10 = LSR1 (MSB<-0), 11 = ASR1.
- Reset (async):
  - State IDLE; PC=RESET_PC; R0..R7=0; flags Z=N=V=0; IR=0.
  - All outputs 0.
  - IDLE -> FETCH on the first edge after reset deasserts.
- State machine (outputs decoded from state):
  - IDLE -> FETCH.
  - FETCH:
    - Drives mem_req=1, mem_we=0, mem_addr=PC.
    - On ready: IR<=mem_rdata[15:0], PC<=PC+1 (wraps modulo 2^ADDR_W); -> DECODE.
    - Otherwise stays in FETCH.
  - DECODE:
    - A<=R[Rn], B<=shift(R[Rm]); -> EXEC.
    - Opcode 000 is a NOP: -> FETCH.
  - EXEC:
    - MOV imm (110/10): C<=sximm8.
    - MOV reg (110/00): C<=B.
    - ALU (101): op 00 ADD, 01 CMP, 10 AND, 11 MVN.
      - CMP: flags only, no write; -> FETCH.
      - ADD/AND/MVN: C<=result.
    - Branch (001): PC<=PC+sximm8 if the condition holds; -> FETCH.
      - Conditions: 000 always, 001 Z, 010 !Z, 011 N!=V, 100 (N!=V)|Z; others never.
    - LDR (011)/STR (100): ADDR<=(A+sximm5)[ADDR_W-1:0]; -> MEM.
    - HALT (111): -> HALT.
    - Otherwise -> WB.
  - MEM:
    - mem_req=1, mem_addr=ADDR; mem_we=1 and mem_wdata=R[Rd] for STR.
    - On ready: LDR loads C<=mem_rdata, -> WB; STR -> FETCH.
  - WB: R[Rd]<=C; -> FETCH.
  - HALT: halted=1, mem_req=0; leaves only on reset.
- Arithmetic and flags:
  - All arithmetic is modulo 2^DATA_W.
  - Flags update only on CMP: Z = (A-B)==0, N = MSB of A-B, V = signed overflow of A-B.
- Latency with mem_ready tied high:
  - ALU/MOV: 4 cycles; CMP and branch: 3 cycles; LDR: 5 cycles; STR: 4 cycles.
  - Each stall cycle adds 1.
- Handshake:
  - mem_addr, mem_we and mem_wdata are held stable while mem_req=1 and mem_ready=0.
  - mem_ready is ignored when mem_req=0.
  - One transaction per request state.
- Boundaries:
  - PC at 2^ADDR_W-1 wraps to 0.
  - A branch offset wraps modulo 2^ADDR_W.
  - Writing R0 updates r0_out on the edge after WB.
  - Reset during a stalled transaction drops mem_req immediately (asynchronously); the write is abandoned.
  - Rd=Rn in ADD: reads use DECODE-time values.

Test Plan:
- Reset/handshake:
  - Stimulus: hold reset 3 cycles, release, mem_ready=1.
  - Required: IDLE 1 cycle, then mem_req=1 with mem_addr=RESET_PC; r0_out=0 and halted=0 throughout reset.
- MOV/ADD:
  - Stimulus: MOV R1,#5; MOV R2,#-3; ADD R0,R1,R2 LSL1.
  - Required: r0_out = (5-6) mod 2^DBG_W = all ones; 12 cycles total.
- CMP/BEQ:
  - Stimulus: CMP R1,R1 then BEQ +2.
  - Required: Z=1; the PC after the branch equals the branch address+3; skipped instructions are never fetched.
- LDR/STR with stalls:
  - Stimulus: STR R1 to [R3+#4] with mem_ready low for 3 cycles, then LDR R0 from the same address.
  - Required: the address/data stay stable during the stall; exactly one write; r0_out = R1 value.
- Wrap:
  - Stimulus: ADDR_W=4, RESET_PC=15, NOP at 15.
  - Required: the next fetch address is 0.
- HALT then reset:
  - Stimulus: HALT; assert reset mid-stalled FETCH on a second run.
  - Required: halted=1 with no further mem_req; reset clears halted, and mem_req falls asynchronously.
